// File: rtl/graph_sram0_responder_if.sv
// Bus bundle between the graph engines / host DMA and the SRAM0 responder.
// Engine strobes are fixed-latency and never stall. The host request channel
// uses valid/ready: a request transfers at a rising edge where host_req_valid
// and host_req_ready are both high, and the payload must stay stable while
// valid is high and ready is low. Host responses are single-cycle pulses with
// no backpressure.
interface graph_sram0_responder_if #(
    parameter int SRAM0_AW = 16
);
    logic                eng_rd_en;
    logic [SRAM0_AW-1:0] eng_rd_addr;
    logic [7:0]          eng_rd_data;
    logic                eng_wr_en;
    logic [SRAM0_AW-1:0] eng_wr_addr;
    logic [7:0]          eng_wr_data;

    logic                host_req_valid;
    logic                host_req_ready;
    logic                host_req_we;
    logic [SRAM0_AW-1:0] host_req_addr;
    logic [7:0]          host_req_wdata;
    logic                host_rsp_valid;
    logic [7:0]          host_rsp_rdata;

    logic                stat_clr;
    logic [15:0]         stat_host_stall;

    modport master (
        output eng_rd_en, eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data,
        output host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        output stat_clr,
        input  eng_rd_data, host_req_ready, host_rsp_valid, host_rsp_rdata,
        input  stat_host_stall
    );

    modport slave (
        input  eng_rd_en, eng_rd_addr, eng_wr_en, eng_wr_addr, eng_wr_data,
        input  host_req_valid, host_req_we, host_req_addr, host_req_wdata,
        input  stat_clr,
        output eng_rd_data, host_req_ready, host_rsp_valid, host_rsp_rdata,
        output stat_host_stall
    );
endinterface

// File: rtl/graph_sram0_responder.sv
// SRAM0 responder: 1R1W byte array shared by the engine strobes (always first)
// and an in-order host request FIFO that only uses idle engine slots.
// Optional macro SRAM0_RAW_BYPASS_EN selects write-first behaviour for a
// same-cycle, same-address read; without it reads return the old contents.
module graph_sram0_responder #(
    parameter int SRAM0_AW        = 16,
    parameter int HOST_FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    graph_sram0_responder_if.slave  bus
);
    localparam int IDX_W     = $clog2(HOST_FIFO_DEPTH);
    localparam int PTR_W     = IDX_W + 1;
    localparam int MEM_BYTES = 1 << SRAM0_AW;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [7:0]          mem [MEM_BYTES];

    logic                fifo_we_mem    [HOST_FIFO_DEPTH];
    logic [SRAM0_AW-1:0] fifo_addr_mem  [HOST_FIFO_DEPTH];
    logic [7:0]          fifo_wdata_mem [HOST_FIFO_DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [7:0]          eng_rd_data_q, eng_rd_data_d;
    logic                host_rsp_valid_q, host_rsp_valid_d;
    logic [7:0]          host_rsp_rdata_q, host_rsp_rdata_d;
    logic [15:0]         stat_q, stat_d;

    logic                fifo_empty, fifo_full, push;
    logic                head_we;
    logic [SRAM0_AW-1:0] head_addr;
    logic [7:0]          head_wdata;
    logic                host_rd_issue, host_wr_issue, head_blocked;
    logic                rd_en, wr_en;
    logic [SRAM0_AW-1:0] rd_addr, wr_addr;
    logic [7:0]          wr_data, rd_byte;

    // FIFO status, head decode, arbitration and array port muxing.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) &&
                     (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
        push       = bus.host_req_valid && !fifo_full;

        head_we    = fifo_we_mem[rd_ptr_q[IDX_W-1:0]];
        head_addr  = fifo_addr_mem[rd_ptr_q[IDX_W-1:0]];
        head_wdata = fifo_wdata_mem[rd_ptr_q[IDX_W-1:0]];

        // The head only takes the port the engine leaves idle this cycle.
        host_rd_issue = !fifo_empty && !head_we && !bus.eng_rd_en;
        host_wr_issue = !fifo_empty &&  head_we && !bus.eng_wr_en;
        head_blocked  = !fifo_empty && !host_rd_issue && !host_wr_issue;

        rd_en   = bus.eng_rd_en || host_rd_issue;
        rd_addr = bus.eng_rd_en ? bus.eng_rd_addr : head_addr;
        wr_en   = bus.eng_wr_en || host_wr_issue;
        wr_addr = bus.eng_wr_en ? bus.eng_wr_addr : head_addr;
        wr_data = bus.eng_wr_en ? bus.eng_wr_data : head_wdata;

`ifdef SRAM0_RAW_BYPASS_EN
        rd_byte = (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
        rd_byte = mem[rd_addr];
`endif
    end

    // Next-state for pointers, read-data holders, response pulse and stall counter.
    always_comb begin
        wr_ptr_d         = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d         = (host_rd_issue || host_wr_issue) ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        eng_rd_data_d    = bus.eng_rd_en ? rd_byte : eng_rd_data_q;
        host_rsp_valid_d = host_rd_issue;
        host_rsp_rdata_d = host_rd_issue ? rd_byte : host_rsp_rdata_q;
        stat_d           = stat_q;
        if (bus.stat_clr) begin
            stat_d = 16'h0000;
        end else if (head_blocked && (stat_q != 16'hFFFF)) begin
            stat_d = stat_q + 16'd1;
        end
    end

    // Control and output registers; reset drops queued requests and in-flight responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            eng_rd_data_q    <= 8'h00;
            host_rsp_valid_q <= 1'b0;
            host_rsp_rdata_q <= 8'h00;
            stat_q           <= 16'h0000;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            eng_rd_data_q    <= eng_rd_data_d;
            host_rsp_valid_q <= host_rsp_valid_d;
            host_rsp_rdata_q <= host_rsp_rdata_d;
            stat_q           <= stat_d;
        end
    end

    // Byte array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Host FIFO payload storage; only the pointers are reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we_mem[wr_ptr_q[IDX_W-1:0]]    <= bus.host_req_we;
            fifo_addr_mem[wr_ptr_q[IDX_W-1:0]]  <= bus.host_req_addr;
            fifo_wdata_mem[wr_ptr_q[IDX_W-1:0]] <= bus.host_req_wdata;
        end
    end

    assign bus.eng_rd_data     = eng_rd_data_q;
    assign bus.host_req_ready  = !fifo_full;
    assign bus.host_rsp_valid  = host_rsp_valid_q;
    assign bus.host_rsp_rdata  = host_rsp_rdata_q;
    assign bus.stat_host_stall = stat_q;
endmodule

// File: tb/tb_graph_sram0_responder.sv
// Bench for graph_sram0_responder: engine port vectors from a table, host
// traffic checked through an expected-response queue, plus hand-written
// sequences for stalls, FIFO full, read/write collision and mid-run reset.
module tb_graph_sram0_responder;
    logic clk;
    logic rst_n;

    graph_sram0_responder_if #(.SRAM0_AW(16)) bus ();

    graph_sram0_responder #(
        .SRAM0_AW(16),
        .HOST_FIFO_DEPTH(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic        rd_en;
        logic [15:0] rd_addr;
        logic        wr_en;
        logic [15:0] wr_addr;
        logic [7:0]  wr_data;
        logic [7:0]  exp_rd;
    } vec_t;

    vec_t vecs[11];

`ifdef SRAM0_RAW_BYPASS_EN
    localparam logic [7:0] RAW_ENG  = 8'h99;
    localparam logic [7:0] RAW_HOST = 8'h33;
`else
    localparam logic [7:0] RAW_ENG  = 8'h12;
    localparam logic [7:0] RAW_HOST = 8'h11;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.eng_rd_en      = 1'b0;
        bus.eng_rd_addr    = '0;
        bus.eng_wr_en      = 1'b0;
        bus.eng_wr_addr    = '0;
        bus.eng_wr_data    = '0;
        bus.host_req_valid = 1'b0;
        bus.host_req_we    = 1'b0;
        bus.host_req_addr  = '0;
        bus.host_req_wdata = '0;
        bus.stat_clr       = 1'b0;
    endtask

    // Driver: offer one host request and hold it until it transfers.
    task automatic host_push(input logic we, input logic [15:0] addr, input logic [7:0] wdata,
                             input logic track, input logic [7:0] exp);
        bit done;
        done = 1'b0;
        bus.host_req_valid = 1'b1;
        bus.host_req_we    = we;
        bus.host_req_addr  = addr;
        bus.host_req_wdata = wdata;
        for (int i = 0; i < 50 && !done; i++) begin
            if (bus.host_req_ready) begin
                done = 1'b1;
                if (track && !we) exp_q.push_back(exp);
            end
            step();
        end
        bus.host_req_valid = 1'b0;
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL host_push_timeout: request at %0h never accepted", addr);
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
    endtask

    // Scoreboard: each response pulse pops the oldest expected byte.
    always @(negedge clk) begin
        if (rst_n && bus.host_rsp_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL host_rsp_unexpected: rdata %0h with nothing pending", bus.host_rsp_rdata);
            end else begin
                check("host_rsp_rdata", bus.host_rsp_rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b0, 16'h0000, 1'b1, 16'h0010, 8'h5A, 8'h00};
        vecs[1]  = '{1'b1, 16'h0010, 1'b0, 16'h0000, 8'h00, 8'h5A};
        vecs[2]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 8'h00, 8'h5A};
        vecs[3]  = '{1'b0, 16'h0010, 1'b0, 16'h0000, 8'h00, 8'h5A};
        vecs[4]  = '{1'b1, 16'h0010, 1'b1, 16'h0040, 8'h77, 8'h5A};
        vecs[5]  = '{1'b1, 16'h0040, 1'b0, 16'h0000, 8'h00, 8'h77};
        vecs[6]  = '{1'b0, 16'h0000, 1'b1, 16'h0041, 8'h12, 8'h77};
        vecs[7]  = '{1'b1, 16'h0041, 1'b1, 16'h0041, 8'h99, RAW_ENG};
        vecs[8]  = '{1'b1, 16'h0041, 1'b0, 16'h0000, 8'h00, 8'h99};
        vecs[9]  = '{1'b0, 16'h0000, 1'b1, 16'h0030, 8'h11, 8'h99};
        vecs[10] = '{1'b1, 16'h0030, 1'b0, 16'h0000, 8'h00, 8'h11};

        idle_inputs();
        rst_n = 1'b0;
        #12;
        check("rst_eng_rd_data", bus.eng_rd_data, 8'h00);
        check("rst_host_rsp_valid", bus.host_rsp_valid, 1'b0);
        check("rst_host_rsp_rdata", bus.host_rsp_rdata, 8'h00);
        check("rst_stat", bus.stat_host_stall, 16'h0000);
        check("rst_ready", bus.host_req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Engine port vectors
        foreach (vecs[i]) begin
            bus.eng_rd_en   = vecs[i].rd_en;
            bus.eng_rd_addr = vecs[i].rd_addr;
            bus.eng_wr_en   = vecs[i].wr_en;
            bus.eng_wr_addr = vecs[i].wr_addr;
            bus.eng_wr_data = vecs[i].wr_data;
            step();
            check($sformatf("eng_vec%0d", i), bus.eng_rd_data, vecs[i].exp_rd);
        end
        idle_inputs();

        // Host write then read with engine idle: response two cycles after acceptance
        host_push(1'b1, 16'h0020, 8'hA5, 1'b1, 8'h00);
        host_push(1'b0, 16'h0020, 8'h00, 1'b1, 8'hA5);
        check("host_rd_not_early", bus.host_rsp_valid, 1'b0);
        step();
        check("host_rd_k2_valid", bus.host_rsp_valid, 1'b1);
        step();
        check("host_rsp_one_pulse", bus.host_rsp_valid, 1'b0);
        check("host_rsp_held", bus.host_rsp_rdata, 8'hA5);
        check("stat_zero_unblocked", bus.stat_host_stall, 16'h0000);

        // Host read blocked by five engine reads
        bus.eng_rd_en   = 1'b1;
        bus.eng_rd_addr = 16'h0010;
        host_push(1'b0, 16'h0020, 8'h00, 1'b1, 8'hA5);
        for (int i = 0; i < 5; i++) step();
        bus.eng_rd_en = 1'b0;
        check("blocked_no_rsp", bus.host_rsp_valid, 1'b0);
        check("stat_five", bus.stat_host_stall, 16'd5);
        step();
        check("blocked_late_valid", bus.host_rsp_valid, 1'b1);
        bus.stat_clr = 1'b1;
        step();
        bus.stat_clr = 1'b0;
        check("stat_cleared", bus.stat_host_stall, 16'h0000);

        // FIFO full while engine reads continuously
        bus.eng_rd_en   = 1'b1;
        bus.eng_rd_addr = 16'h0040;
        host_push(1'b0, 16'h0010, 8'h00, 1'b1, 8'h5A);
        host_push(1'b0, 16'h0020, 8'h00, 1'b1, 8'hA5);
        bus.host_req_valid = 1'b1;
        bus.host_req_we    = 1'b0;
        bus.host_req_addr  = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("full_ready%0d", i), bus.host_req_ready, 1'b0);
            step();
        end
        check("full_no_rsp", bus.host_rsp_valid, 1'b0);
        bus.eng_rd_en = 1'b0;
        host_push(1'b0, 16'h0040, 8'h00, 1'b1, 8'h77);
        wait_drain("full_drain");
        step();
        check("ready_after_drain", bus.host_req_ready, 1'b1);

        // Same-cycle engine write and host read at one address
        host_push(1'b0, 16'h0030, 8'h00, 1'b1, RAW_HOST);
        bus.eng_wr_en   = 1'b1;
        bus.eng_wr_addr = 16'h0030;
        bus.eng_wr_data = 8'h33;
        step();
        bus.eng_wr_en = 1'b0;
        wait_drain("raw_drain");
        bus.eng_rd_en   = 1'b1;
        bus.eng_rd_addr = 16'h0030;
        step();
        bus.eng_rd_en = 1'b0;
        check("raw_mem_after", bus.eng_rd_data, 8'h33);

        // Reset with two host reads queued
        bus.eng_rd_en   = 1'b1;
        bus.eng_rd_addr = 16'h0010;
        host_push(1'b0, 16'h0020, 8'h00, 1'b0, 8'h00);
        host_push(1'b0, 16'h0030, 8'h00, 1'b0, 8'h00);
        rst_n = 1'b0;
        #1;
        check("rst_mid_ready", bus.host_req_ready, 1'b1);
        check("rst_mid_stat", bus.stat_host_stall, 16'h0000);
        step();
        rst_n = 1'b1;
        bus.eng_rd_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post_rst_no_rsp%0d", i), bus.host_rsp_valid, 1'b0);
            step();
        end
        check("post_rst_stat", bus.stat_host_stall, 16'h0000);
        bus.eng_rd_en   = 1'b1;
        bus.eng_rd_addr = 16'h0020;
        step();
        check("post_rst_mem20", bus.eng_rd_data, 8'hA5);
        bus.eng_rd_addr = 16'h0030;
        step();
        check("post_rst_mem30", bus.eng_rd_data, 8'h33);
        bus.eng_rd_en = 1'b0;
        step();
        check("exp_q_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/graph_sram0_responder.md
# graph_sram0_responder

Responder end of the graph engines' SRAM0 byte interface. It owns the SRAM0 byte array and serves the fixed-latency engine read/write strobes (math and element-wise engines) with exactly one cycle of read latency and no stalls. It also serves a lower-priority host/DMA port through a small in-order request FIFO. Host requests use the engine port's idle read or write slot and are never allowed to delay an engine access.

## Interface
Parameters:
- SRAM0_AW, 16, byte address width; the array holds 2**SRAM0_AW bytes.
- HOST_FIFO_DEPTH, 2, depth of the host request FIFO; power of 2, at least 2.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- eng_rd_en  in  1  engine read strobe, one byte.
- eng_rd_addr  in  SRAM0_AW  engine read address.
- eng_rd_data  out  8  engine read data; valid in the cycle after eng_rd_en, then held until the next engine read.
- eng_wr_en  in  1  engine write strobe.
- eng_wr_addr  in  SRAM0_AW  engine write address.
- eng_wr_data  in  8  engine write data.
- host_req_valid  in  1  host request valid.
- host_req_ready  out  1  host request accepted when valid and ready are both high at a rising edge.
- host_req_we  in  1  1 = write, 0 = read.
- host_req_addr  in  SRAM0_AW  host byte address.
- host_req_wdata  in  8  host write data.
- host_rsp_valid  out  1  one-cycle pulse carrying host read data; no backpressure.
- host_rsp_rdata  out  8  host read data; held between pulses.
- stat_clr  in  1  synchronous clear of stat_host_stall.
- stat_host_stall  out  16  saturating count of cycles in which the host head request was blocked.

## Operation
- The array has one read port and one write port per cycle (1R1W).
- The engine owns both ports by default. The arbiter is fixed-priority, with the engine first.
- Host FIFO:
  - Entries hold {we, addr, wdata} and are serviced strictly in order.
  - host_req_ready = !full.
  - A push and a pop may happen in the same cycle.
- Head issue, evaluated every cycle the FIFO is non-empty:
  - Head is a read and eng_rd_en = 0: read the array, pop the entry, and drive host_rsp_valid = 1 next cycle with the data.
  - Head is a write and eng_wr_en = 0: write the array and pop the entry.
  - Otherwise the head is blocked. If stat_host_stall < 16'hFFFF, it increments by 1.
- A read never passes a blocked write. A head blocked by an engine write therefore stalls any host reads queued behind it.
- An engine write and a host write never occur in the same cycle. The same holds for an engine read and a host read.
- Read and write to the same address in the same cycle (engine or host read against engine or host write): see Configuration.
- stat_clr has priority over increment: the counter becomes 0 in that cycle.
- Out-of-range addresses cannot occur, because address width equals array width.
- Array contents are not reset.

## Timing
- Reset values (asynchronous):
  - eng_rd_data = 8'h00
  - host_rsp_valid = 0
  - host_rsp_rdata = 8'h00
  - stat_host_stall = 0
  - FIFO empty, so host_req_ready = 1 during and after reset
- Engine read: eng_rd_en high in cycle N gives eng_rd_data valid in cycle N+1. The latency is fixed and never stalls.
- Engine write: takes effect at the edge ending the strobe cycle. A read in the following cycle sees the new data.
- Host request accepted at edge k:
  - It can issue no earlier than cycle k+1.
  - An unblocked read gives host_rsp_valid in cycle k+2.
  - Each blocked cycle adds 1 cycle.
- Host throughput is 1 request per cycle when unblocked.
- Reset asserted mid-operation: pending FIFO entries and any in-flight response are discarded. No host_rsp_valid follows the reset. Array contents are retained.

## Configuration
- SRAM0_RAW_BYPASS_EN defined: write-first. A same-cycle, same-address read returns the byte being written, for either read port.
- Not defined: read-first. The read returns the old array contents.

## Test plan
- Engine write 8'h5A to 16'h0010, then engine read 16'h0010 next cycle -> eng_rd_data = 8'h5A one cycle after eng_rd_en, held while eng_rd_en stays low.
- Host write 8'hA5 to 16'h0020, then host read 16'h0020, engine idle -> host_rsp_valid pulses 2 cycles after the read is accepted, with 8'hA5; stat_host_stall = 0.
- Host read pending while eng_rd_en is high for 5 consecutive cycles -> response arrives 5 cycles late, stat_host_stall = 5; stat_clr then gives 0.
- With HOST_FIFO_DEPTH = 2 and engine reads continuous, push 2 host reads -> host_req_ready = 0 and a third request is held. When the engine goes idle, responses come in order and ready returns to 1.
- Memory 16'h0030 = 8'h11; in one cycle, engine writes 8'h33 to 16'h0030 and the host head reads 16'h0030 -> host_rsp_rdata = 8'h11 without the macro, 8'h33 with SRAM0_RAW_BYPASS_EN.
- Two host reads queued, then rst_n pulsed low for 1 cycle -> no host_rsp_valid, host_req_ready = 1, stat_host_stall = 0, and engine reads return pre-reset contents.
